mac_lanes: RTL and testbench
============================

# mac_lanes

Multi-lane, pipelined multiply-accumulate unit: the next generation of the single-lane MAC used in the minilab datapaths. It runs LANES independent accumulators in lockstep from one enable. Each accumulator has a configurable width and takes signed or unsigned operands. It also keeps a shared term counter and per-lane sticky overflow flags. It sits between the operand-fetch logic (FIFOs or memory readers) and the result-capture/readback logic of a matrix-vector or dot-product engine.

## Interface
- DATA_WIDTH, 8, operand width per lane (bits)
- LANES, 4, number of parallel lanes
- ACC_WIDTH, 3*DATA_WIDTH, accumulator width per lane; must be ≥ 2*DATA_WIDTH
- CNT_WIDTH, 16, width of term counter

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  operand valid; lane operands sampled this edge
- clr  in  1  synchronous clear of accumulators, counter, flags, pipeline
- sgn  in  1  1 = operands two's-complement signed, 0 = unsigned; sampled with operands
- a_in  in  LANES*DATA_WIDTH  lane i operand A at bits [i*DATA_WIDTH +: DATA_WIDTH]
- b_in  in  LANES*DATA_WIDTH  lane i operand B, same packing
- acc_out  out  LANES*ACC_WIDTH  lane i accumulator at [i*ACC_WIDTH +: ACC_WIDTH]
- cnt  out  CNT_WIDTH  products accumulated since last clr/rst
- ovf  out  LANES  sticky per-lane overflow flag
- busy  out  1  a product is in flight (stage-1 valid)

## Operation
- Two-stage pipeline per lane.
  - Stage 1 (product register): on en, p_i <= A_i*B_i as a 2*DATA_WIDTH-bit signed or unsigned product per sgn. The v1 bit and the mode bit are registered with it.
  - Stage 2 (accumulate): when v1, acc_i <= acc_i + ext(p_i). ext() sign-extends if the carried mode is signed and zero-extends otherwise. cnt increments alongside.
- Each product carries its own mode bit. Mixing modes within a run is legal; extension and overflow checks use the carried mode.
- Priority at every edge: rst > clr > normal operation.
- rst or clr:
  - acc_i, p_i, v1, cnt and ovf all go to 0 at that edge.
  - An en in the same cycle is ignored.
  - Any in-flight product is discarded.
- Overflow:
  - Signed product: set ovf[i] when the true sum falls outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned product: set ovf[i] on carry out of ACC_WIDTH.
  - ovf[i] stays set until rst or clr.
- cnt saturates at 2^CNT_WIDTH-1; it does not wrap.
- busy = v1.
- Back-to-back en is allowed every cycle; throughput is one product per lane per cycle, with no stalls.

## Timing
- Reset values: acc_out = 0, cnt = 0, ovf = 0, busy = 0.
- Latency: en sampled at edge t → product registered at t, busy high in cycle t..t+1. The accumulator and cnt update at edge t+1 and are visible in the following cycle (2 edges from operand presentation to result).
- clr at edge t+1 while the product from edge t is in flight → that product never reaches acc. acc = 0 after edge t+1.
- en at edge t and clr at edge t+1 with en also high at t+1 → both products are dropped.
- Outputs are registers only; there are no combinational paths from inputs to outputs.

## Configuration
- MAC_SAT_EN defined: on overflow, acc_i clamps instead of wrapping, and ovf[i] is still set.
  - Signed: clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned: clamps to 2^ACC_WIDTH-1.
  - Later accumulations continue from the clamped value.
- MAC_SAT_EN undefined: modular (wrap-around) accumulation, and ovf[i] is still set.

## Test plan
- Reset: hold rst 2 cycles mid-stream with en high → acc_out = 0, cnt = 0, ovf = 0, busy = 0 the cycle after the first rst edge. The in-flight product is discarded.
- Unsigned accumulate: defaults, lane0 A = 0xFF, B = 0xFF, en for 3 cycles, sgn = 0 → two cycles after the last en, lane0 acc = 0x02FA03, cnt = 3. Lanes fed zeros stay at 0.
- Signed accumulate: lane1 A = 0x80 (-128), B = 0x7F, en 2 cycles, sgn = 1 → lane1 acc = 0xFF8100 (-32512), ovf = 0.
- Clear mid-pipeline: en at edge t (A = B = 3), clr at edge t+1 → acc = 0, cnt = 0 after t+1. The next single en with A = 2, B = 5 → acc = 10, cnt = 1.
- Overflow: ACC_WIDTH = 16, unsigned 0xFF×0xFF twice.
  - Without MAC_SAT_EN: acc = 0xFC02, ovf[0] = 1.
  - With MAC_SAT_EN: acc = 0xFFFF, ovf[0] = 1.
  - In both builds, ovf[0] clears only on clr.
- Counter saturation: CNT_WIDTH = 4, 20 consecutive en → cnt stops at 15. The accumulators still take all 20 products.

Source files
------------

// File: rtl/mac_lanes.sv
// mac_lanes: LANES-wide, two-stage pipelined multiply-accumulate unit.
// Stage 1 registers each lane's product together with a shared valid bit and a mode bit
// (signed/unsigned). Stage 2 adds the mode-extended product into the lane accumulator.
// A shared term counter saturates, and each lane has a sticky overflow flag.
// Build option: define MAC_SAT_EN to clamp accumulators on overflow instead of wrapping.
module mac_lanes #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 3*DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           clr,
    input  logic                           sgn,
    input  logic [LANES*DATA_WIDTH-1:0]    a_in,
    input  logic [LANES*DATA_WIDTH-1:0]    b_in,
    output logic [LANES*ACC_WIDTH-1:0]     acc_out,
    output logic [CNT_WIDTH-1:0]           cnt,
    output logic [LANES-1:0]               ovf,
    output logic                           busy
);

    localparam int PW = 2*DATA_WIDTH;
    localparam int XW = ACC_WIDTH - PW + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic v1;
    logic mode1;

    // Shared stage-1 valid/mode bits and the saturating count of accumulated terms
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            v1    <= 1'b0;
            mode1 <= 1'b0;
            cnt   <= '0;
        end else begin
            v1    <= en;
            mode1 <= sgn;
            if (v1 && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    assign busy = v1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PW-1:0]        a_ext;
        logic [PW-1:0]        b_ext;
        logic [PW-1:0]        prod_d;
        logic [PW-1:0]        prod_q;
        logic [ACC_WIDTH-1:0] acc_q;
        logic [ACC_WIDTH-1:0] acc_d;
        logic [ACC_WIDTH:0]   sum;
        logic                 lane_ovf;
        logic                 ovf_q;

        // Extend operands to product width by mode; the low PW bits of the product are then exact for both modes
        always_comb begin
            a_ext  = {{DATA_WIDTH{sgn & a_in[i*DATA_WIDTH + DATA_WIDTH - 1]}}, a_in[i*DATA_WIDTH +: DATA_WIDTH]};
            b_ext  = {{DATA_WIDTH{sgn & b_in[i*DATA_WIDTH + DATA_WIDTH - 1]}}, b_in[i*DATA_WIDTH +: DATA_WIDTH]};
            prod_d = a_ext * b_ext;
        end

        // One-bit-wider sum using the carried mode; the extra bit exposes signed overflow or unsigned carry
        always_comb begin
            if (mode1) begin
                sum      = {acc_q[ACC_WIDTH-1], acc_q} + {{XW{prod_q[PW-1]}}, prod_q};
                lane_ovf = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
            end else begin
                sum      = {1'b0, acc_q} + {{XW{1'b0}}, prod_q};
                lane_ovf = sum[ACC_WIDTH];
            end
            acc_d = sum[ACC_WIDTH-1:0];
`ifdef MAC_SAT_EN
            if (lane_ovf) begin
                if (!mode1) begin
                    acc_d = '1;
                end else if (sum[ACC_WIDTH]) begin
                    acc_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
                end else begin
                    acc_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end
`endif
        end

        // Lane product register, accumulator and sticky overflow flag
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                prod_q <= '0;
                acc_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (en) begin
                    prod_q <= prod_d;
                end
                if (v1) begin
                    acc_q <= acc_d;
                    if (lane_ovf) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
        end

        assign acc_out[i*ACC_WIDTH +: ACC_WIDTH] = acc_q;
        assign ovf[i] = ovf_q;
    end

endmodule

// File: tb/tb_mac_lanes.sv
// tb_mac_lanes: bench for mac_lanes. A default-parameter instance is checked every cycle
// against a reference model through a scoreboard queue; a narrow instance (16-bit
// accumulators, 4-bit counter) is checked with directed overflow and saturation constants.
module tb_mac_lanes;

    localparam int AW = 24;

    typedef struct {
        int          due;
        logic [95:0] acc;
        logic [15:0] cnt;
        logic [3:0]  ovf;
    } exp_t;

`ifdef MAC_SAT_EN
    localparam logic [15:0] OVF_U_EXP  = 16'hFFFF;
    localparam logic [15:0] OVF_U2_EXP = 16'hFFFF;
    localparam logic [15:0] OVF_S_EXP  = 16'h7FFF;
    localparam logic [23:0] MIX_EXP    = 24'hFFFFFF;
`else
    localparam logic [15:0] OVF_U_EXP  = 16'hFC02;
    localparam logic [15:0] OVF_U2_EXP = 16'hFC03;
    localparam logic [15:0] OVF_S_EXP  = 16'h8000;
    localparam logic [23:0] MIX_EXP    = 24'h0000FE;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        sgn;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [95:0] acc_big;
    logic [15:0] cnt_big;
    logic [3:0]  ovf_big;
    logic        busy_big;
    logic [63:0] acc_small;
    logic [3:0]  cnt_small;
    logic [3:0]  ovf_small;
    logic        busy_small;

    exp_t          sb_q[$];
    exp_t          mon_item;
    logic [AW-1:0] m_acc [4];
    logic [3:0]    m_ovf;
    int            m_cnt;
    int            cyc = 0;
    int            n_asserts = 0;
    int            n_fails = 0;

    mac_lanes dut_big (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sgn(sgn),
        .a_in(a_in), .b_in(b_in),
        .acc_out(acc_big), .cnt(cnt_big), .ovf(ovf_big), .busy(busy_big)
    );

    mac_lanes #(.ACC_WIDTH(16), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .sgn(sgn),
        .a_in(a_in), .b_in(b_in),
        .acc_out(acc_small), .cnt(cnt_small), .ovf(ovf_small), .busy(busy_small)
    );

    // Free-running clock and edge counter used to schedule scoreboard entries
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference lane update on true integer values: returns {overflow, new accumulator}
    function automatic logic [AW:0] lane_step(input logic [AW-1:0] acc, input logic [7:0] a,
                                              input logic [7:0] b, input logic s);
        longint p;
        longint v;
        longint sum;
        longint lo;
        longint hi;
        logic [AW:0] res;
        if (s) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            v  = longint'($signed(acc));
            lo = -(longint'(1) <<< (AW-1));
            hi = (longint'(1) <<< (AW-1)) - 1;
        end else begin
            p  = longint'(a) * longint'(b);
            v  = longint'(acc);
            lo = 0;
            hi = (longint'(1) <<< AW) - 1;
        end
        sum = v + p;
        res[AW] = (sum < lo) || (sum > hi);
`ifdef MAC_SAT_EN
        if (sum > hi) sum = hi;
        if (sum < lo) sum = lo;
`endif
        res[AW-1:0] = sum[AW-1:0];
        return res;
    endfunction

    task automatic check_output(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, update the model and scoreboard, wait one cycle
    task automatic apply_stimulus(input logic r, input logic c, input logic e, input logic s,
                                  input logic [31:0] a, input logic [31:0] b);
        exp_t        item;
        logic [AW:0] res;
        rst = r; clr = c; en = e; sgn = s; a_in = a; b_in = b;
        if (r || c) begin
            while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
            for (int i = 0; i < 4; i++) m_acc[i] = '0;
            m_ovf = '0;
            m_cnt = 0;
        end else if (e) begin
            for (int i = 0; i < 4; i++) begin
                res = lane_step(m_acc[i], a[i*8 +: 8], b[i*8 +: 8], s);
                m_acc[i] = res[AW-1:0];
                if (res[AW]) m_ovf[i] = 1'b1;
            end
            if (m_cnt < 65535) m_cnt++;
            item.due = cyc + 2;
            item.acc = {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
            item.cnt = 16'(m_cnt);
            item.ovf = m_ovf;
            sb_q.push_back(item);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Scoreboard: pop each expected result on the cycle it becomes visible and compare
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_item = sb_q.pop_front();
            check_output("sb_acc", acc_big, mon_item.acc);
            check_output("sb_cnt", 96'(cnt_big), 96'(mon_item.cnt));
            check_output("sb_ovf", 96'(ovf_big), 96'(mon_item.ovf));
        end
    end

    // Directed sequence
    initial begin
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        m_ovf = '0;
        m_cnt = 0;
        rst = 1'b1; clr = 1'b0; en = 1'b0; sgn = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        idle(1);
        check_output("reset_acc", acc_big, 96'(0));
        check_output("reset_cnt", 96'(cnt_big), 96'(0));
        check_output("reset_ovf", 96'(ovf_big), 96'(0));
        check_output("reset_busy", 96'(busy_big), 96'(0));

        $display("[TB] reset mid-stream");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h5, 32'h7);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h5, 32'h7);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h5, 32'h7);
        check_output("midrst_acc", acc_big, 96'(0));
        check_output("midrst_cnt", 96'(cnt_big), 96'(0));
        check_output("midrst_busy", 96'(busy_big), 96'(0));
        check_output("midrst_busy_small", 96'(busy_small), 96'(0));
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h5, 32'h7);
        idle(1);
        check_output("postrst_acc", acc_big, 96'(0));

        $display("[TB] unsigned accumulate");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFF, 32'hFF);
        check_output("busy_inflight", 96'(busy_big), 96'(1));
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFF, 32'hFF);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFF, 32'hFF);
        idle(2);
        check_output("uns_lane0", 96'(acc_big[23:0]), 96'(24'h02FA03));
        check_output("uns_cnt", 96'(cnt_big), 96'(3));
        check_output("uns_other_lanes", 96'(acc_big[95:24]), 96'(0));
        check_output("uns_busy_idle", 96'(busy_big), 96'(0));

        $display("[TB] signed accumulate");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h00008000, 32'h00007F00);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h00008000, 32'h00007F00);
        idle(2);
        check_output("sgn_lane1", 96'(acc_big[47:24]), 96'(24'hFF8100));
        check_output("sgn_ovf", 96'(ovf_big), 96'(0));

        $display("[TB] clear mid-pipeline");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h3, 32'h3);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h3, 32'h3);
        check_output("clr_acc", acc_big, 96'(0));
        check_output("clr_cnt", 96'(cnt_big), 96'(0));
        idle(1);
        check_output("clr_dropped_acc", acc_big, 96'(0));
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h2, 32'h5);
        idle(2);
        check_output("clr_next_lane0", 96'(acc_big[23:0]), 96'(10));
        check_output("clr_next_cnt", 96'(cnt_big), 96'(1));

        $display("[TB] unsigned overflow on 16-bit accumulator");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFF, 32'hFF);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFF, 32'hFF);
        idle(2);
        check_output("ovfu_acc", 96'(acc_small[15:0]), 96'(OVF_U_EXP));
        check_output("ovfu_flag", 96'(ovf_small), 96'(4'b0001));
        idle(2);
        check_output("ovfu_sticky", 96'(ovf_small), 96'(4'b0001));
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h1);
        idle(2);
        check_output("ovfu_continue", 96'(acc_small[15:0]), 96'(OVF_U2_EXP));
        check_output("ovfu_still_set", 96'(ovf_small), 96'(4'b0001));
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check_output("ovfu_cleared", 96'(ovf_small), 96'(0));
        check_output("ovfu_acc_cleared", 96'(acc_small), 96'(0));

        $display("[TB] signed overflow on 16-bit accumulator");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h80000000);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h80000000);
        idle(2);
        check_output("ovfs_acc", 96'(acc_small[63:48]), 96'(OVF_S_EXP));
        check_output("ovfs_flag", 96'(ovf_small), 96'(4'b1000));
        check_output("ovfs_big_lane3", 96'(acc_big[95:72]), 96'(24'h008000));

        $display("[TB] mixed modes");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h00FF0000, 32'h00010000);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h00FF0000, 32'h00010000);
        idle(2);
        check_output("mix_lane2", 96'(acc_big[71:48]), 96'(MIX_EXP));
        check_output("mix_ovf", 96'(ovf_big), 96'(4'b0100));

        $display("[TB] counter saturation");
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 20; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h1);
        idle(2);
        check_output("cntsat_small", 96'(cnt_small), 96'(15));
        check_output("cntsat_small_acc", 96'(acc_small[15:0]), 96'(20));
        check_output("cntsat_big", 96'(cnt_big), 96'(20));

        idle(3);
        check_output("sb_drained", 96'(sb_q.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
